// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight register writes with a T_new
// countdown and derives stall, D/E forward selects and a saturating stall counter.
module hazard_scoreboard #(
  parameter int NUM_STAGES = 3,
  parameter int NUM_READ   = 2,
  parameter int ADDR_W     = 5,
  parameter int T_W        = 2,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         d_valid,
  input  logic [NUM_READ*ADDR_W-1:0]   d_raddr,
  input  logic [NUM_READ*T_W-1:0]      d_tuse,
  input  logic [ADDR_W-1:0]            d_waddr,
  input  logic [T_W-1:0]               d_tnew,
  input  logic                         d_md_use,
  input  logic                         md_busy,
  input  logic                         flush,
  output logic                         stall,
  output logic [NUM_READ*SEL_W-1:0]    d_fwd_sel,
  output logic [NUM_READ*SEL_W-1:0]    e_fwd_sel,
  output logic [CNT_W-1:0]             stall_cnt
);

  logic [NUM_STAGES-1:0]      slot_valid;
  logic [ADDR_W-1:0]          slot_waddr [NUM_STAGES];
  logic [T_W-1:0]             slot_tnew  [NUM_STAGES];
  logic                       slot_md;
  logic [NUM_READ*ADDR_W-1:0] e_raddr;

  logic [NUM_READ-1:0]        d_hit;
  logic [T_W-1:0]             d_win_tnew [NUM_READ];
  logic [SEL_W-1:0]           d_win_sel  [NUM_READ];
  logic [NUM_READ-1:0]        e_hit;
  logic [T_W-1:0]             e_win_tnew [NUM_READ];
  logic [SEL_W-1:0]           e_win_sel  [NUM_READ];
  logic                       data_stall;
  logic                       md_stall;

  function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - T_W'(1);
  endfunction

  // Scan oldest to youngest so the youngest matching slot overwrites the winner.
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      d_hit[i]      = 1'b0;
      d_win_tnew[i] = '0;
      d_win_sel[i]  = '0;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (d_raddr[i*ADDR_W +: ADDR_W] != '0 && slot_valid[k] &&
            slot_waddr[k] == d_raddr[i*ADDR_W +: ADDR_W]) begin
          d_hit[i]      = 1'b1;
          d_win_tnew[i] = slot_tnew[k];
          d_win_sel[i]  = SEL_W'(k + 1);
        end
      end
    end
  end

  // The E instruction only forwards from older slots; slot 0 is itself.
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      e_hit[i]      = 1'b0;
      e_win_tnew[i] = '0;
      e_win_sel[i]  = '0;
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        if (e_raddr[i*ADDR_W +: ADDR_W] != '0 && slot_valid[k] &&
            slot_waddr[k] == e_raddr[i*ADDR_W +: ADDR_W]) begin
          e_hit[i]      = 1'b1;
          e_win_tnew[i] = slot_tnew[k];
          e_win_sel[i]  = SEL_W'(k + 1);
        end
      end
    end
  end

  always_comb begin
    data_stall = 1'b0;
    d_fwd_sel  = '0;
    e_fwd_sel  = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      if (d_hit[i] && d_win_tnew[i] > d_tuse[i*T_W +: T_W]) begin
        data_stall = 1'b1;
      end
      if (d_hit[i] && d_win_tnew[i] == '0) begin
        d_fwd_sel[i*SEL_W +: SEL_W] = d_win_sel[i];
      end
      if (slot_valid[0] && e_hit[i] && e_win_tnew[i] == '0) begin
        e_fwd_sel[i*SEL_W +: SEL_W] = e_win_sel[i];
      end
    end
    md_stall = d_md_use & (md_busy | (slot_valid[0] & slot_md));
    stall    = d_valid & (data_stall | md_stall);
  end

  // Slots shift one stage per cycle while counting T_new down toward zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        slot_waddr[k] <= '0;
        slot_tnew[k]  <= '0;
      end
      slot_md   <= 1'b0;
      e_raddr   <= '0;
      stall_cnt <= '0;
    end else begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_waddr[k] <= slot_waddr[k-1];
        slot_tnew[k]  <= tnew_dec(slot_tnew[k-1]);
      end
      slot_valid[0] <= d_valid & ~stall & ~flush;
      slot_waddr[0] <= d_waddr;
      slot_tnew[0]  <= d_tnew;
      slot_md       <= d_md_use;
      e_raddr       <= d_raddr;
      if (stall && stall_cnt != {CNT_W{1'b1}}) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two configurations share stimulus and are checked
// every cycle against an age-based model, plus literal directed scenarios.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_valid;
  logic [14:0] d_raddr;
  logic [5:0]  d_tuse;
  logic [4:0]  d_waddr;
  logic [1:0]  d_tnew;
  logic        d_md_use;
  logic        md_busy;
  logic        flush;

  logic        stall0, stall1;
  logic [3:0]  dsel0, esel0;
  logic [8:0]  dsel1, esel1;
  logic [31:0] cnt0;
  logic [3:0]  cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_STAGES(3), .NUM_READ(2), .ADDR_W(5), .T_W(2), .SEL_W(2), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_raddr(d_raddr[9:0]), .d_tuse(d_tuse[3:0]),
    .d_waddr(d_waddr), .d_tnew(d_tnew), .d_md_use(d_md_use), .md_busy(md_busy), .flush(flush),
    .stall(stall0), .d_fwd_sel(dsel0), .e_fwd_sel(esel0), .stall_cnt(cnt0)
  );

  hazard_scoreboard #(.NUM_STAGES(4), .NUM_READ(3), .ADDR_W(5), .T_W(2), .SEL_W(3), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_raddr(d_raddr), .d_tuse(d_tuse),
    .d_waddr(d_waddr), .d_tnew(d_tnew), .d_md_use(d_md_use), .md_busy(md_busy), .flush(flush),
    .stall(stall1), .d_fwd_sel(dsel1), .e_fwd_sel(esel1), .stall_cnt(cnt1)
  );

  // Model: each issued instruction remembered by age; current T_new = max(t0 - age, 0).
  typedef struct packed {
    logic        v;
    logic [4:0]  waddr;
    logic [1:0]  t0;
    logic        md;
    logic [14:0] raddr;
  } ent_t;

  ent_t   hist [2][4];
  int     exp_stall [2];
  int     exp_dsel [2][3];
  int     exp_esel [2][3];
  longint exp_cnt [2];
  bit     model_ok = 1'b0;

  function automatic int ns_of(input int c);
    return (c == 0) ? 3 : 4;
  endfunction

  function automatic int nr_of(input int c);
    return (c == 0) ? 2 : 3;
  endfunction

  function automatic int aged(input logic [1:0] t0, input int age);
    return (int'(t0) > age) ? int'(t0) - age : 0;
  endfunction

  function automatic void model_eval(input int c);
    bit ds;
    bit md;
    ds = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_dsel[c][i] = 0;
      exp_esel[c][i] = 0;
    end
    for (int i = 0; i < nr_of(c); i++) begin
      logic [4:0] ra;
      int tu;
      ra = d_raddr[i*5 +: 5];
      tu = int'(d_tuse[i*2 +: 2]);
      for (int k = 0; k < ns_of(c); k++) begin
        if (ra != 0 && hist[c][k].v && hist[c][k].waddr == ra) begin
          if (aged(hist[c][k].t0, k) > tu) ds = 1'b1;
          if (aged(hist[c][k].t0, k) == 0) exp_dsel[c][i] = k + 1;
          break;
        end
      end
      if (hist[c][0].v) begin
        logic [4:0] ea;
        ea = hist[c][0].raddr[i*5 +: 5];
        for (int k = 1; k < ns_of(c); k++) begin
          if (ea != 0 && hist[c][k].v && hist[c][k].waddr == ea) begin
            if (aged(hist[c][k].t0, k) == 0) exp_esel[c][i] = k + 1;
            break;
          end
        end
      end
    end
    md = d_md_use && (md_busy || (hist[c][0].v && hist[c][0].md));
    exp_stall[c] = (d_valid && (ds || md)) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] wa, input logic [1:0] tn,
                               input logic [14:0] ra, input logic [5:0] tu, input logic mu,
                               input logic mb, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    d_valid  = v;
    d_waddr  = wa;
    d_tnew   = tn;
    d_raddr  = ra;
    d_tuse   = tu;
    d_md_use = mu;
    md_busy  = mb;
    flush    = fl;
    rst      = rs;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < 4; k++) hist[c][k] = '0;
        exp_cnt[c] = 0;
      end
      model_ok = 1'b1;
    end else if (model_ok) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 3; k >= 1; k--) hist[c][k] = hist[c][k-1];
        hist[c][0].v     = d_valid && exp_stall[c] == 0 && !flush;
        hist[c][0].waddr = d_waddr;
        hist[c][0].t0    = d_tnew;
        hist[c][0].md    = d_md_use;
        hist[c][0].raddr = d_raddr;
        if (exp_stall[c] != 0 && exp_cnt[c] < ((c == 0) ? 64'hFFFF_FFFF : 64'd15))
          exp_cnt[c] = exp_cnt[c] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      model_eval(0);
      model_eval(1);
      checkOutput("cfg0 stall", 64'(stall0), 64'(exp_stall[0]));
      checkOutput("cfg1 stall", 64'(stall1), 64'(exp_stall[1]));
      checkOutput("cfg0 stall_cnt", 64'(cnt0), 64'(exp_cnt[0]));
      checkOutput("cfg1 stall_cnt", 64'(cnt1), 64'(exp_cnt[1]));
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("cfg0 d_fwd_sel[%0d]", i), 64'(dsel0[i*2 +: 2]), 64'(exp_dsel[0][i]));
        checkOutput($sformatf("cfg0 e_fwd_sel[%0d]", i), 64'(esel0[i*2 +: 2]), 64'(exp_esel[0][i]));
      end
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("cfg1 d_fwd_sel[%0d]", i), 64'(dsel1[i*3 +: 3]), 64'(exp_dsel[1][i]));
        checkOutput($sformatf("cfg1 e_fwd_sel[%0d]", i), 64'(esel1[i*3 +: 3]), 64'(exp_esel[1][i]));
      end
    end
  end

  initial begin
    rst = 1'b1; d_valid = 1'b0; d_raddr = '0; d_tuse = '0; d_waddr = '0;
    d_tnew = '0; d_md_use = 1'b0; md_busy = 1'b0; flush = 1'b0;

    @(negedge clk);
    checkOutput("reset stall", 64'(stall0), 64'd0);
    checkOutput("reset stall_cnt", 64'(cnt0), 64'd0);
    checkOutput("reset d_fwd_sel", 64'(dsel0), 64'd0);
    checkOutput("reset e_fwd_sel", 64'(esel0), 64'd0);

    // Back-to-back ALU: producer $8 tnew=1, consumer tuse=1 picks it up in E.
    applyStimulus(1, 5'd8, 2'd1, 15'd0, 6'd0, 0, 0, 0, 0);
    applyStimulus(1, 5'd0, 2'd0, 15'd8, 6'd1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("alu stall", 64'(stall0), 64'd0);
    checkOutput("alu d_fwd_sel", 64'(dsel0[1:0]), 64'd0);
    applyStimulus(0, 5'd0, 2'd0, 15'd0, 6'd0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("alu e_fwd_sel", 64'(esel0[1:0]), 64'd2);

    // Load-use: $9 tnew=2 against tuse=0 stalls twice then forwards from W.
    applyStimulus(1, 5'd9, 2'd2, 15'd0, 6'd0, 0, 0, 0, 0);
    applyStimulus(1, 5'd0, 2'd0, 15'd9, 6'd0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("load stall1", 64'(stall0), 64'd1);
    applyStimulus(1, 5'd0, 2'd0, 15'd9, 6'd0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("load stall2", 64'(stall0), 64'd1);
    applyStimulus(1, 5'd0, 2'd0, 15'd9, 6'd0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("load released", 64'(stall0), 64'd0);
    checkOutput("load d_fwd_sel", 64'(dsel0[1:0]), 64'd3);
    checkOutput("load stall_cnt", 64'(cnt0), 64'd2);

    // Youngest wins among two ready writers of $4.
    applyStimulus(1, 5'd4, 2'd0, 15'd0, 6'd0, 0, 0, 0, 0);
    applyStimulus(1, 5'd4, 2'd0, 15'd0, 6'd0, 0, 0, 0, 0);
    applyStimulus(1, 5'd0, 2'd0, 15'd4, 6'd0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("youngest d_fwd_sel", 64'(dsel0[1:0]), 64'd1);

    // Register $0 never matches even with a slow writer of $0.
    applyStimulus(1, 5'd0, 2'd3, 15'd0, 6'd0, 0, 0, 0, 0);
    applyStimulus(1, 5'd0, 2'd0, 15'd0, 6'd0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("r0 stall", 64'(stall0), 64'd0);
    checkOutput("r0 d_fwd_sel", 64'(dsel0), 64'd0);

    // MD interlock: exactly as many stall cycles as md_busy cycles.
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1, 5'd0, 2'd0, 15'd0, 6'd0, 1, 1, 0, 0);
      @(negedge clk);
      checkOutput($sformatf("md busy stall %0d", n), 64'(stall0), 64'd1);
    end
    applyStimulus(1, 5'd0, 2'd0, 15'd0, 6'd0, 1, 0, 0, 0);
    @(negedge clk);
    checkOutput("md released", 64'(stall0), 64'd0);
    checkOutput("md stall_cnt", 64'(cnt0), 64'd7);

    // Oldest slot of the deep configuration forwards with sel=4.
    applyStimulus(1, 5'd5, 2'd0, 15'd0, 6'd0, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) applyStimulus(0, 5'd0, 2'd0, 15'd0, 6'd0, 0, 0, 0, 0);
    applyStimulus(1, 5'd0, 2'd0, {5'd5, 5'd0, 5'd5}, 6'd0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("deep d_fwd_sel[0]", 64'(dsel1[2:0]), 64'd4);
    checkOutput("deep d_fwd_sel[2]", 64'(dsel1[8:6]), 64'd4);
    checkOutput("shallow retired sel", 64'(dsel0[1:0]), 64'd0);

    // Reset while stalled empties the scoreboard and the counter.
    applyStimulus(1, 5'd9, 2'd2, 15'd0, 6'd0, 0, 0, 0, 0);
    applyStimulus(1, 5'd0, 2'd0, 15'd9, 6'd0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("pre-reset stall", 64'(stall0), 64'd1);
    applyStimulus(1, 5'd0, 2'd0, 15'd9, 6'd0, 0, 0, 0, 1);
    applyStimulus(1, 5'd0, 2'd0, 15'd9, 6'd0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("post-reset stall", 64'(stall0), 64'd0);
    checkOutput("post-reset stall_cnt", 64'(cnt0), 64'd0);
    checkOutput("post-reset cfg1 stall_cnt", 64'(cnt1), 64'd0);

    // Saturation of the 4-bit counter while the 32-bit one keeps counting.
    for (int n = 0; n < 20; n++) applyStimulus(1, 5'd0, 2'd0, 15'd0, 6'd0, 1, 1, 0, 0);
    applyStimulus(0, 5'd0, 2'd0, 15'd0, 6'd0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("sat cfg0 stall_cnt", 64'(cnt0), 64'd20);
    checkOutput("sat cfg1 stall_cnt", 64'(cnt1), 64'd15);

    for (int n = 0; n < 2000; n++) begin
      applyStimulus($urandom_range(0, 9) < 8,
                    5'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)),
                    {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                    6'($urandom),
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 199) == 0);
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
